clk_div_gen: RTL and testbench

//  Parametrised multi-channel clock divider, successor to the fixed /2 VGA clock divider.

---
 rtl/clk_div_gen_if.sv | 22 ++
 rtl/clk_div_gen.sv | 103 ++++++++++
 tb/tb_clk_div_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// Divisor-load handshake bundle for clk_div_gen: load request, ack/err pulses and per-channel pending flags.
interface clk_div_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  logic              div_load;
  logic [2:0]        div_ch;
  logic [DIV_W-1:0]  div_val;
  logic              load_ack;
  logic              load_err;
  logic [NUM_CH-1:0] div_pend;

  modport master (
    output div_load, div_ch, div_val,
    input  load_ack, load_err, div_pend
  );

  modport slave (
    input  div_load, div_ch, div_val,
    output load_ack, load_err, div_pend
  );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel runtime-loadable clock divider with clk_en strobes; divisors change only at period wrap.
// Optional CLK_DIV_ODD_DUTY50_EN adds a negedge stage giving 50% duty for odd divisors.
module clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en,
  clk_div_gen_if.slave      load_bus
);

  logic [DIV_W-1:0]  cnt      [NUM_CH];
  logic [DIV_W-1:0]  n        [NUM_CH];
  logic [DIV_W-1:0]  pend_val [NUM_CH];
  logic [DIV_W-1:0]  cnt_nx   [NUM_CH];
  logic [DIV_W-1:0]  n_nx     [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] q;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] q_nx;
  logic [NUM_CH-1:0] hit;
  logic              load_ok;

  // A pending divisor takes over only where a new period starts, or at once while the channel is idle.
  always_comb begin
    cnt_nx  = '{default: '0};
    n_nx    = '{default: '0};
    wrap    = '0;
    apply   = '0;
    q_nx    = '0;
    hit     = '0;
    load_ok = load_bus.div_load && (load_bus.div_val >= DIV_W'(2)) &&
              (int'(load_bus.div_ch) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]   = (cnt[i] == n[i] - DIV_W'(1));
      cnt_nx[i] = wrap[i] ? '0 : cnt[i] + DIV_W'(1);
      apply[i]  = pend[i] && (wrap[i] || !ch_en[i]);
      n_nx[i]   = apply[i] ? pend_val[i] : n[i];
      q_nx[i]   = ch_en[i] && (cnt_nx[i] >= n_nx[i] - (n_nx[i] >> 1));
      hit[i]    = load_ok && (int'(load_bus.div_ch) == i);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      load_bus.load_ack <= 1'b0;
      load_bus.load_err <= 1'b0;
      pend              <= '0;
      q                 <= '0;
      strobe            <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        n[i]        <= DIV_W'(DEFAULT_DIV);
        pend_val[i] <= DIV_W'(DEFAULT_DIV);
      end
    end else begin
      load_bus.load_ack <= load_ok;
      load_bus.load_err <= load_bus.div_load && !load_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= ch_en[i] ? cnt_nx[i] : '0;
        n[i]      <= n_nx[i];
        q[i]      <= q_nx[i];
        strobe[i] <= q_nx[i] && !q[i];
        if (hit[i]) begin
          pend[i]     <= 1'b1;
          pend_val[i] <= load_bus.div_val;
        end else if (apply[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  assign load_bus.div_pend = pend;
  assign clk_en            = strobe;

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic [NUM_CH-1:0] qn;
  logic [NUM_CH-1:0] odd;

  // Half-cycle delayed copy stretches the high phase of odd divisors by half a sys_clk.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) qn <= '0;
    else            qn <= q;
  end

  always_comb begin
    odd = '0;
    for (int i = 0; i < NUM_CH; i++) odd[i] = n[i][0];
  end

  assign clk_out = q | (qn & odd);
`else
  assign clk_out = q;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus randomized loads/enables against a waveform-level model.
module tb_clk_div_gen;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] clk_en;

  clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) load_bus ();

  clk_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ch_en     (ch_en),
    .clk_out   (clk_out),
    .clk_en    (clk_en),
    .load_bus  (load_bus)
  );

  always #5 sys_clk = ~sys_clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: each channel plays out a period as "lows then highs"; divisors change only when a period is exhausted.
  int                modelN       [NUM_CH];
  int                modelPendVal [NUM_CH];
  bit                modelPend    [NUM_CH];
  bit                modelFresh   [NUM_CH];
  bit                modelQ       [NUM_CH];
  int                lowsLeft     [NUM_CH];
  int                highsLeft    [NUM_CH];
  bit                expAck;
  bit                expErr;
  bit [NUM_CH-1:0]   expOut;
  bit [NUM_CH-1:0]   expEn;
  bit [NUM_CH-1:0]   expPend;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      modelN[i]       = 2;
      modelPendVal[i] = 2;
      modelPend[i]    = 1'b0;
      modelFresh[i]   = 1'b1;
      modelQ[i]       = 1'b0;
      lowsLeft[i]     = 0;
      highsLeft[i]    = 0;
    end
    expAck  = 1'b0;
    expErr  = 1'b0;
    expOut  = '0;
    expEn   = '0;
    expPend = '0;
  endfunction

  function automatic void modelEdge(input bit [NUM_CH-1:0] en, input bit load, input int ch, input int val);
    bit ok;
    bit prevQ;
    int h;
    ok     = load && (val >= 2) && (ch < NUM_CH);
    expAck = ok;
    expErr = load && !ok;
    for (int i = 0; i < NUM_CH; i++) begin
      prevQ = modelQ[i];
      if (!en[i]) begin
        lowsLeft[i]   = 0;
        highsLeft[i]  = 0;
        modelFresh[i] = 1'b1;
        modelQ[i]     = 1'b0;
        if (modelPend[i]) begin
          modelN[i]    = modelPendVal[i];
          modelPend[i] = 1'b0;
        end
      end else begin
        if (modelFresh[i]) begin
          h             = modelN[i] / 2;
          lowsLeft[i]   = modelN[i] - h - 1;
          highsLeft[i]  = h;
          modelFresh[i] = 1'b0;
        end else if (lowsLeft[i] == 0 && highsLeft[i] == 0) begin
          if (modelPend[i]) begin
            modelN[i]    = modelPendVal[i];
            modelPend[i] = 1'b0;
          end
          h            = modelN[i] / 2;
          lowsLeft[i]  = modelN[i] - h;
          highsLeft[i] = h;
        end
        if (lowsLeft[i] > 0) begin
          lowsLeft[i]--;
          modelQ[i] = 1'b0;
        end else begin
          highsLeft[i]--;
          modelQ[i] = 1'b1;
        end
      end
      expEn[i] = modelQ[i] && !prevQ;
`ifdef CLK_DIV_ODD_DUTY50_EN
      expOut[i] = modelQ[i] || (prevQ && (modelN[i] % 2 == 1));
`else
      expOut[i] = modelQ[i];
`endif
      if (ok && ch == i) begin
        modelPendVal[i] = val;
        modelPend[i]    = 1'b1;
      end
      expPend[i] = modelPend[i];
    end
  endfunction

  task automatic applyStimulus(input bit [NUM_CH-1:0] en, input bit load, input int ch, input int val);
    ch_en             = en;
    load_bus.div_load = load;
    load_bus.div_ch   = 3'(ch);
    load_bus.div_val  = DIV_W'(val);
    @(posedge sys_clk);
    #1;
    modelEdge(en, load, ch, val);
    checkOutput("load_ack", 32'(load_bus.load_ack), 32'(expAck));
    checkOutput("load_err", 32'(load_bus.load_err), 32'(expErr));
    checkOutput("div_pend", 32'(load_bus.div_pend), 32'(expPend));
    checkOutput("clk_out",  32'(clk_out),           32'(expOut));
    checkOutput("clk_en",   32'(clk_en),            32'(expEn));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"},  32'(load_bus.load_ack), 32'd0);
    checkOutput({tag, "_err"},  32'(load_bus.load_err), 32'd0);
    checkOutput({tag, "_pend"}, 32'(load_bus.div_pend), 32'd0);
    checkOutput({tag, "_out"},  32'(clk_out),           32'd0);
    checkOutput({tag, "_en"},   32'(clk_en),            32'd0);
  endtask

  // Called #1 after a posedge: drop reset mid-cycle, check outputs clear without a clock, release before the next edge.
  task automatic asyncReset();
    #2 sys_rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    #2 sys_rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    bit [NUM_CH-1:0] en;
    ch_en             = '0;
    load_bus.div_load = 1'b0;
    load_bus.div_ch   = '0;
    load_bus.div_val  = '0;
    modelReset();

    repeat (3) @(posedge sys_clk);
    #1 checkAllZero("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Defaults: both channels divide by 2 from the first edge.
    repeat (6) applyStimulus('1, 1'b0, 0, 0);

    // Load ch0 N=5 mid-period, watch pending clear and the new period settle.
    applyStimulus('1, 1'b1, 0, 5);
    repeat (15) applyStimulus('1, 1'b0, 0, 0);

    // Rejected loads: divisor too small, then channel out of range.
    applyStimulus('1, 1'b1, 0, 1);
    applyStimulus('1, 1'b0, 0, 0);
    applyStimulus('1, 1'b1, 7, 4);
    repeat (3) applyStimulus('1, 1'b0, 0, 0);
    applyStimulus('1, 1'b1, 1, 0);

    // Back-to-back loads: the later one wins.
    applyStimulus('1, 1'b1, 0, 4);
    applyStimulus('1, 1'b1, 0, 6);
    repeat (20) applyStimulus('1, 1'b0, 0, 0);

    // Channel 1 at N=3, disabled for 10 cycles then restarted.
    applyStimulus('1, 1'b1, 1, 3);
    repeat (8) applyStimulus('1, 1'b0, 0, 0);
    repeat (10) applyStimulus(2'b01, 1'b0, 0, 0);
    repeat (10) applyStimulus('1, 1'b0, 0, 0);

    // Disabled channel picks up a new divisor right away; then reset in the middle of running periods.
    applyStimulus(2'b01, 1'b1, 1, 7);
    repeat (3) applyStimulus(2'b01, 1'b0, 0, 0);
    repeat (9) applyStimulus('1, 1'b0, 0, 0);
    applyStimulus('1, 1'b1, 0, 3);
    asyncReset();
    repeat (6) applyStimulus('1, 1'b0, 0, 0);

    // Randomized loads, enables and occasional resets.
    en = '1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit load;
      int ch;
      int val;
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
      load = ($urandom_range(0, 3) == 0);
      ch   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NUM_CH - 1));
      val  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 7));
      applyStimulus(en, load, ch, val);
      if ($urandom_range(0, 199) == 0) asyncReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
